// File: rtl/spi_regbank_pkg.sv
// Shared types for the SPI register-bank controller: FSM state encoding and default widths.
package spi_regbank_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_FETCH,
    RD_HOLD,
    WR_WAIT,
    WR_COMMIT,
    WAIT_END
  } state_e;

endpackage

// File: rtl/spi_regbank_arb.sv
// Register-array ownership: SPI owns it during fetch/commit, otherwise a local request is granted the same cycle.
// Local read data strobe (lcl_rvalid_o) follows a read grant by one clk; withheld requests simply retry.
module spi_regbank_arb
  import spi_regbank_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  state_e state_i,
  input  logic   lcl_req_i,
  input  logic   lcl_we_i,
  input  logic   lcl_in_range_i,
  output logic   spi_own_o,
  output logic   lcl_gnt_o,
  output logic   lcl_wr_o,
  output logic   lcl_rd_o,
  output logic   lcl_rvalid_o
);

  logic rvalid_q, rvalid_d;

  assign spi_own_o = (state_i == RD_FETCH) || (state_i == WR_COMMIT);
  assign lcl_gnt_o = lcl_req_i & ~spi_own_o;
  // Out-of-range local writes are granted but dropped.
  assign lcl_wr_o  = lcl_gnt_o & lcl_we_i & lcl_in_range_i;
  assign lcl_rd_o  = lcl_gnt_o & ~lcl_we_i;
  assign rvalid_d  = lcl_rd_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rvalid_q <= 1'b0;
    else          rvalid_q <= rvalid_d;
  end

  assign lcl_rvalid_o = rvalid_q;

endmodule

// File: rtl/spi_regbank_ctrl.sv
// SPI register-bank controller: sequences slave reads/writes, shares the array with a local port; tx data valid 2 clk after addr_dv rises.
// Local requests stall while SPI owns the array. Optional macro SPI_REGBANK_RO_MASK_EN makes RO_MASK registers SPI read-only.
module spi_regbank_ctrl
  import spi_regbank_pkg::*;
#(
  parameter int                  ADDR_W   = ADDR_W_DEF,
  parameter int                  DATA_W   = DATA_W_DEF,
  parameter int                  NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_W-1:0]            spi_addr,
  input  logic                         spi_addr_dv,
  input  logic                         spi_rw,
  input  logic [DATA_W-1:0]            spi_rx_d,
  input  logic                         spi_rxdv,
  output logic [DATA_W-1:0]            spi_tx_d,
  output logic                         spi_tx_en,
  input  logic                         lcl_req,
  input  logic                         lcl_we,
  input  logic [ADDR_W-1:0]            lcl_addr,
  input  logic [DATA_W-1:0]            lcl_wdata,
  output logic                         lcl_gnt,
  output logic [DATA_W-1:0]            lcl_rdata,
  output logic                         lcl_rvalid,
  output logic                         spi_err,
  input  logic                         err_clr,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out
);

  localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);
`ifdef SPI_REGBANK_RO_MASK_EN
  localparam logic              RO_EN      = 1'b1;
`else
  localparam logic              RO_EN      = 1'b0;
`endif

  state_e                             state_q, state_d;
  logic                               addr_dv_q, rxdv_q;
  logic [DATA_W-1:0]                  tx_d_q, tx_d_d;
  logic [DATA_W-1:0]                  lcl_rdata_q, lcl_rdata_d;
  logic                               err_q, err_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;

  logic              addr_dv_re, rxdv_re;
  logic              spi_in_range, lcl_in_range, spi_ro, spi_wr, err_set;
  logic              spi_own, lcl_wr, lcl_rd;
  logic [IDX_W-1:0]  spi_idx, lcl_idx, rd_idx;
  logic [DATA_W-1:0] rd_data;

  assign addr_dv_re   = spi_addr_dv & ~addr_dv_q;
  assign rxdv_re      = spi_rxdv & ~rxdv_q;
  assign spi_in_range = {1'b0, spi_addr} < NUM_REGS_A;
  assign lcl_in_range = {1'b0, lcl_addr} < NUM_REGS_A;
  assign spi_idx      = spi_addr[IDX_W-1:0];
  assign lcl_idx      = lcl_addr[IDX_W-1:0];
  assign spi_ro       = RO_EN & RO_MASK[spi_idx];

  spi_regbank_arb u_arb (
    .clk            (clk),
    .reset_n        (reset_n),
    .state_i        (state_q),
    .lcl_req_i      (lcl_req),
    .lcl_we_i       (lcl_we),
    .lcl_in_range_i (lcl_in_range),
    .spi_own_o      (spi_own),
    .lcl_gnt_o      (lcl_gnt),
    .lcl_wr_o       (lcl_wr),
    .lcl_rd_o       (lcl_rd),
    .lcl_rvalid_o   (lcl_rvalid)
  );

  // Single read port: whoever owns the array this cycle selects the index.
  assign rd_idx  = spi_own ? spi_idx : lcl_idx;
  assign rd_data = regs_q[rd_idx];
  assign spi_wr  = (state_q == WR_COMMIT) & spi_in_range & ~spi_ro;
  assign err_set = ((state_q == RD_FETCH) & ~spi_in_range) |
                   ((state_q == WR_COMMIT) & (~spi_in_range | spi_ro));

  always_comb begin
    state_d = state_q;
    tx_d_d  = tx_d_q;
    unique case (state_q)
      IDLE:      if (addr_dv_re) state_d = spi_rw ? RD_FETCH : WR_WAIT;
      RD_FETCH: begin
        tx_d_d  = spi_in_range ? rd_data : '0;
        state_d = RD_HOLD;
      end
      RD_HOLD: begin
        if (!spi_addr_dv) begin
          state_d = IDLE;
          tx_d_d  = '0;
        end
      end
      WR_WAIT: begin
        if (!spi_addr_dv)  state_d = IDLE;
        else if (rxdv_re)  state_d = WR_COMMIT;
      end
      WR_COMMIT: state_d = WAIT_END;
      WAIT_END:  if (!spi_addr_dv) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    regs_d      = regs_q;
    lcl_rdata_d = lcl_rdata_q;
    err_d       = err_q;
    if (spi_wr)      regs_d[spi_idx] = spi_rx_d;
    else if (lcl_wr) regs_d[lcl_idx] = lcl_wdata;
    if (lcl_rd)      lcl_rdata_d = lcl_in_range ? rd_data : '0;
    if (err_set)     err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_dv_q   <= 1'b0;
      rxdv_q      <= 1'b0;
      tx_d_q      <= '0;
      lcl_rdata_q <= '0;
      err_q       <= 1'b0;
      regs_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_dv_q   <= spi_addr_dv;
      rxdv_q      <= spi_rxdv;
      tx_d_q      <= tx_d_d;
      lcl_rdata_q <= lcl_rdata_d;
      err_q       <= err_d;
      regs_q      <= regs_d;
    end
  end

  assign spi_tx_d  = tx_d_q;
  assign spi_tx_en = (state_q == RD_HOLD);
  assign lcl_rdata = lcl_rdata_q;
  assign spi_err   = err_q;
  assign regs_out  = regs_q;

endmodule

// File: tb/tb_spi_regbank_ctrl.sv
// Self-checking bench for spi_regbank_ctrl: vector table, corner-case sequences, randomized ops vs. a register-file model.
module tb_spi_regbank_ctrl;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 16;
  localparam int RW       = NUM_REGS * DATA_W;
  localparam logic [NUM_REGS-1:0] RO_MASK = 16'h0001;
`ifdef SPI_REGBANK_RO_MASK_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  logic              clk;
  logic              reset_n;
  logic [ADDR_W-1:0] spi_addr;
  logic              spi_addr_dv;
  logic              spi_rw;
  logic [DATA_W-1:0] spi_rx_d;
  logic              spi_rxdv;
  logic [DATA_W-1:0] spi_tx_d;
  logic              spi_tx_en;
  logic              lcl_req;
  logic              lcl_we;
  logic [ADDR_W-1:0] lcl_addr;
  logic [DATA_W-1:0] lcl_wdata;
  logic              lcl_gnt;
  logic [DATA_W-1:0] lcl_rdata;
  logic              lcl_rvalid;
  logic              spi_err;
  logic              err_clr;
  logic [RW-1:0]     regs_out;

  spi_regbank_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_addr(spi_addr), .spi_addr_dv(spi_addr_dv), .spi_rw(spi_rw),
    .spi_rx_d(spi_rx_d), .spi_rxdv(spi_rxdv),
    .spi_tx_d(spi_tx_d), .spi_tx_en(spi_tx_en),
    .lcl_req(lcl_req), .lcl_we(lcl_we), .lcl_addr(lcl_addr), .lcl_wdata(lcl_wdata),
    .lcl_gnt(lcl_gnt), .lcl_rdata(lcl_rdata), .lcl_rvalid(lcl_rvalid),
    .spi_err(spi_err), .err_clr(err_clr), .regs_out(regs_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Operation kinds used by the vector table
  localparam int K_SW = 0, K_SR = 1, K_LW = 2, K_LR = 3;
  typedef struct {
    int        kind;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;
  vec_t tbl[18];

  logic [RW-1:0] shadow;
  logic [7:0]    mem[NUM_REGS];
  logic          m_err;
  logic [7:0]    rd;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; spi_addr = '0; spi_addr_dv = 1'b0; spi_rw = 1'b0; spi_rx_d = '0;
    spi_rxdv = 1'b0; lcl_req = 1'b0; lcl_we = 1'b0; lcl_addr = '0; lcl_wdata = '0; err_clr = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    spi_addr = a; spi_rw = 1'b0; spi_addr_dv = 1'b1;
    step();
    spi_rx_d = d; spi_rxdv = 1'b1;
    step();
    step();
    spi_rxdv = 1'b0; spi_addr_dv = 1'b0;
    step();
  endtask

  task automatic spi_read(input logic [6:0] a, output logic [7:0] d);
    spi_addr = a; spi_rw = 1'b1; spi_addr_dv = 1'b1;
    step();
    chk("tx_en_early", spi_tx_en, 1'b0);
    step();
    chk("tx_en_rise", spi_tx_en, 1'b1);
    d = spi_tx_d;
    spi_addr_dv = 1'b0;
    step();
    chk("tx_en_drop", spi_tx_en, 1'b0);
    chk("tx_d_drop", spi_tx_d, 8'h00);
  endtask

  task automatic lcl_acc(input logic we, input logic [6:0] a, input logic [7:0] wd, output logic [7:0] d);
    lcl_req = 1'b1; lcl_we = we; lcl_addr = a; lcl_wdata = wd;
    #1;
    chk("lcl_gnt", lcl_gnt, 1'b1);
    step();
    lcl_req = 1'b0;
    chk("lcl_rvalid", lcl_rvalid, !we);
    d = lcl_rdata;
    step();
    chk("lcl_rvalid_drop", lcl_rvalid, 1'b0);
  endtask

  function automatic logic [RW-1:0] pack_mem();
    logic [RW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = mem[i];
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{K_LW, 7'h01, 8'h5A, 8'h00, 1'b0};
    tbl[1]  = '{K_SR, 7'h01, 8'h00, 8'h5A, 1'b0};
    tbl[2]  = '{K_SW, 7'h07, 8'hC3, 8'h00, 1'b0};
    tbl[3]  = '{K_LR, 7'h07, 8'h00, 8'hC3, 1'b0};
    tbl[4]  = '{K_SR, 7'h0F, 8'h00, 8'h00, 1'b0};
    tbl[5]  = '{K_SW, 7'h0F, 8'h81, 8'h00, 1'b0};
    tbl[6]  = '{K_LR, 7'h0F, 8'h00, 8'h81, 1'b0};
    tbl[7]  = '{K_SW, 7'h10, 8'h99, 8'h00, 1'b1};
    tbl[8]  = '{K_LR, 7'h10, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{K_SR, 7'h7F, 8'h00, 8'h00, 1'b1};
    tbl[10] = '{K_LW, 7'h20, 8'h77, 8'h00, 1'b0};
    tbl[11] = '{K_LR, 7'h00, 8'h00, 8'h00, 1'b0};
    tbl[12] = '{K_SR, 7'h07, 8'h00, 8'hC3, 1'b0};
    tbl[13] = '{K_SW, 7'h40, 8'h44, 8'h00, 1'b1};
    tbl[14] = '{K_SR, 7'h00, 8'h00, 8'h00, 1'b0};
    tbl[15] = '{K_LW, 7'h0E, 8'hEE, 8'h00, 1'b0};
    tbl[16] = '{K_SR, 7'h0E, 8'h00, 8'hEE, 1'b0};
    tbl[17] = '{K_LR, 7'h0E, 8'h00, 8'hEE, 1'b0};

    // Reset state
    reset_n = 1'b0; spi_addr = '0; spi_addr_dv = 1'b0; spi_rw = 1'b0; spi_rx_d = '0;
    spi_rxdv = 1'b0; lcl_req = 1'b0; lcl_we = 1'b0; lcl_addr = '0; lcl_wdata = '0; err_clr = 1'b0;
    step(); step();
    chk("rst_regs", regs_out, '0);
    chk("rst_tx_d", spi_tx_d, 8'h00);
    chk("rst_tx_en", spi_tx_en, 1'b0);
    chk("rst_gnt", lcl_gnt, 1'b0);
    chk("rst_rdata", lcl_rdata, 8'h00);
    chk("rst_rvalid", lcl_rvalid, 1'b0);
    chk("rst_err", spi_err, 1'b0);
    reset_n = 1'b1;
    step();

    // Vector table
    for (int i = 0; i < 18; i++) begin
      clr_err();
      rd = 8'h00;
      case (tbl[i].kind)
        K_SW:    spi_write(tbl[i].addr, tbl[i].data);
        K_SR:    spi_read(tbl[i].addr, rd);
        K_LW:    lcl_acc(1'b1, tbl[i].addr, tbl[i].data, rd);
        default: lcl_acc(1'b0, tbl[i].addr, 8'h00, rd);
      endcase
      if (tbl[i].kind == K_SR || tbl[i].kind == K_LR)
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), spi_err, tbl[i].exp_err);
    end

    // Reset after activity clears everything
    reset_n = 1'b0;
    #1;
    chk("rst2_regs", regs_out, '0);
    chk("rst2_rdata", lcl_rdata, 8'h00);
    do_reset();
    shadow = '0;

    // SPI write: reg 3 visible exactly one cycle after the commit cycle
    spi_addr = 7'd3; spi_rw = 1'b0; spi_addr_dv = 1'b1;
    step();
    spi_rx_d = 8'hA5; spi_rxdv = 1'b1;
    step();
    chk("wr_before_commit", regs_out[31:24], 8'h00);
    step();
    chk("wr_reg3", regs_out[31:24], 8'hA5);
    shadow[31:24] = 8'hA5;
    chk("wr_all", regs_out, shadow);
    chk("wr_err", spi_err, 1'b0);
    spi_rxdv = 1'b0; spi_addr_dv = 1'b0;
    step();

    // SPI read of reg 5 with a local read held across the fetch cycle
    lcl_acc(1'b1, 7'd5, 8'h3C, rd);
    shadow[47:40] = 8'h3C;
    spi_addr = 7'd5; spi_rw = 1'b1; spi_addr_dv = 1'b1;
    step();
    chk("rd_tx_en_fetch", spi_tx_en, 1'b0);
    lcl_req = 1'b1; lcl_we = 1'b0; lcl_addr = 7'd5;
    #1;
    chk("rd_gnt_fetch", lcl_gnt, 1'b0);
    step();
    chk("rd_tx_en_hold", spi_tx_en, 1'b1);
    chk("rd_tx_d_hold", spi_tx_d, 8'h3C);
    chk("rd_gnt_hold", lcl_gnt, 1'b1);
    chk("rd_rvalid_nogrant", lcl_rvalid, 1'b0);
    spi_addr_dv = 1'b0;
    step();
    lcl_req = 1'b0;
    chk("rd_tx_en_end", spi_tx_en, 1'b0);
    chk("rd_tx_d_end", spi_tx_d, 8'h00);
    chk("rd_lcl_rvalid", lcl_rvalid, 1'b1);
    chk("rd_lcl_rdata", lcl_rdata, 8'h3C);
    step();
    chk("rd_lcl_rvalid_drop", lcl_rvalid, 1'b0);

    // Collision on reg 2: SPI commits 0x22 first, held local write of 0x11 lands next cycle
    spi_addr = 7'd2; spi_rw = 1'b0; spi_addr_dv = 1'b1;
    step();
    spi_rx_d = 8'h22; spi_rxdv = 1'b1;
    step();
    lcl_req = 1'b1; lcl_we = 1'b1; lcl_addr = 7'd2; lcl_wdata = 8'h11;
    #1;
    chk("col_gnt_commit", lcl_gnt, 1'b0);
    step();
    chk("col_spi_val", regs_out[23:16], 8'h22);
    chk("col_gnt_after", lcl_gnt, 1'b1);
    step();
    lcl_req = 1'b0;
    chk("col_final", regs_out[23:16], 8'h11);
    shadow[23:16] = 8'h11;
    spi_rxdv = 1'b0; spi_addr_dv = 1'b0;
    step();
    chk("col_all", regs_out, shadow);

    // Out-of-range write with err_clr in the commit cycle: set wins
    clr_err();
    chk("oor_err_pre", spi_err, 1'b0);
    spi_addr = 7'h40; spi_rw = 1'b0; spi_addr_dv = 1'b1;
    step();
    spi_rx_d = 8'h5A; spi_rxdv = 1'b1;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("oor_err_set_prio", spi_err, 1'b1);
    spi_rxdv = 1'b0; spi_addr_dv = 1'b0;
    step();
    chk("oor_err_sticky", spi_err, 1'b1);
    chk("oor_noreg", regs_out, shadow);
    clr_err();
    chk("oor_err_clr", spi_err, 1'b0);

    // Aborted write: addr_dv drops before any rx data
    spi_addr = 7'd3; spi_rw = 1'b0; spi_rx_d = 8'h77; spi_addr_dv = 1'b1;
    step(); step();
    spi_addr_dv = 1'b0;
    step(); step();
    chk("abort_regs", regs_out, shadow);
    chk("abort_err", spi_err, 1'b0);
    spi_read(7'd3, rd);
    chk("abort_then_read", rd, 8'hA5);

    // addr_dv drops during fetch: one hold cycle then exit
    spi_addr = 7'd3; spi_rw = 1'b1; spi_addr_dv = 1'b1;
    step();
    spi_addr_dv = 1'b0;
    step();
    chk("short_tx_en", spi_tx_en, 1'b1);
    chk("short_tx_d", spi_tx_d, 8'hA5);
    step();
    chk("short_tx_en_end", spi_tx_en, 1'b0);
    chk("short_tx_d_end", spi_tx_d, 8'h00);

    // Read-only register 0
    clr_err();
    spi_write(7'd0, 8'hFF);
`ifdef SPI_REGBANK_RO_MASK_EN
    chk("ro_spi_blocked", regs_out[7:0], 8'h00);
    chk("ro_err", spi_err, 1'b1);
    clr_err();
    lcl_acc(1'b1, 7'd0, 8'hFF, rd);
    chk("ro_lcl_write", regs_out[7:0], 8'hFF);
`else
    chk("rw_spi_write0", regs_out[7:0], 8'hFF);
    chk("rw_err", spi_err, 1'b0);
`endif

    // Randomized operations against the register-file model
    do_reset();
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 8'h00;
    m_err = 1'b0;
    for (int n = 0; n < 300; n++) begin
      int op, a;
      logic [7:0] d;
      op = $urandom_range(0, 4);
      a  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, NUM_REGS - 1);
      d  = 8'($urandom_range(0, 255));
      case (op)
        0: begin
          spi_write(7'(a), d);
          if (a >= NUM_REGS || (RO_EN && RO_MASK[a])) m_err = 1'b1;
          else mem[a] = d;
        end
        1: begin
          spi_read(7'(a), rd);
          chk($sformatf("rnd%0d_spi_rd", n), rd, (a < NUM_REGS) ? mem[a] : 8'h00);
          if (a >= NUM_REGS) m_err = 1'b1;
        end
        2: begin
          lcl_acc(1'b1, 7'(a), d, rd);
          if (a < NUM_REGS) mem[a] = d;
        end
        3: begin
          lcl_acc(1'b0, 7'(a), 8'h00, rd);
          chk($sformatf("rnd%0d_lcl_rd", n), rd, (a < NUM_REGS) ? mem[a] : 8'h00);
        end
        default: begin
          clr_err();
          m_err = 1'b0;
        end
      endcase
      chk($sformatf("rnd%0d_regs", n), regs_out, pack_mem());
      chk($sformatf("rnd%0d_err", n), spi_err, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
